// File: rtl/irq_ctrl_n_pkg.sv
// irq_ctrl_n_pkg: register offsets and pin sense encodings for irq_ctrl_n
package irq_ctrl_n_pkg;
  localparam logic [1:0] PINMSK_OFS = 2'd0;
  localparam logic [1:0] PINSNS_OFS = 2'd1;
  localparam logic [1:0] PINFLG_OFS = 2'd2;
  localparam logic [1:0] DEVMSK_OFS = 2'd3;
  localparam logic [1:0] SNS_LOW  = 2'b00;
  localparam logic [1:0] SNS_ANY  = 2'b01;
  localparam logic [1:0] SNS_FALL = 2'b10;
  localparam logic [1:0] SNS_RISE = 2'b11;
endpackage

// File: rtl/irq_ctrl_n_pin_chan.sv
// irq_pin_chan: synchroniser, edge detector and flag for one external pin
module irq_pin_chan
  import irq_ctrl_n_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ena_i,
  input  logic       pin_i,
  input  logic [1:0] sns,
  input  logic       guard,
  input  logic       clr,
  input  logic       msk,
  output logic       flag,
  output logic       irq
);
  // top bit is the previous sample, the one below it the synchronised pin
  logic [SYNC_STAGES:0] sr;
  logic p_s, p_q, ev;
  assign p_s = sr[SYNC_STAGES-1];
  assign p_q = sr[SYNC_STAGES];
  assign ev = ~guard & (sns == SNS_ANY  ? p_s ^ p_q :
                        sns == SNS_FALL ? p_q & ~p_s :
                        sns == SNS_RISE ? ~p_q & p_s : 1'b0);
  assign irq = msk & (sns == SNS_LOW ? ~p_s : flag);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sr   <= '0;
      flag <= 1'b0;
    end else if (ena_i) begin
      sr   <= {sr[SYNC_STAGES-1:0], pin_i};
      flag <= sns == SNS_LOW ? 1'b0 : ev ? 1'b1 : clr ? 1'b0 : flag;
    end
endmodule

// File: rtl/irq_ctrl_n.sv
// irq_ctrl_n: parametrised external/device interrupt controller on the AVR I/O bus
module irq_ctrl_n
  import irq_ctrl_n_pkg::*;
#(
  parameter int         N_PIN       = 2,
  parameter int         N_DEV       = 3,
  parameter logic [5:0] BASE_ADR    = 6'h38,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ena_i,
  input  logic [5:0]             adr_i,
  input  logic [7:0]             data_i,
  output logic [7:0]             data_o,
  input  logic                   re_i,
  input  logic                   we_i,
  output logic                   selected_o,
  input  logic [N_PIN-1:0]       pin_irq_i,
  input  logic [N_DEV-1:0]       dev_irq_i,
  input  logic [N_PIN-1:0]       irq_ack_i,
  output logic [N_PIN+N_DEV-1:0] ext_irq_o
);
  localparam logic [7:0] PIN_M = 8'((1 << N_PIN) - 1);
  localparam logic [7:0] SNS_M = 8'((1 << (2 * N_PIN)) - 1);
  localparam logic [7:0] DEV_M = 8'((1 << N_DEV) - 1);
  logic [5:0] ofs;
  logic hit, wr, sns_wr, flg_wr;
  logic [7:0] pinmsk, pinsns, devmsk;
  logic [N_PIN-1:0] flg, pin_irq;
  assign ofs        = adr_i - BASE_ADR;
  assign hit        = ofs[5:2] == 4'd0;
  assign selected_o = (re_i | we_i) & hit;
  assign wr         = we_i & ena_i & hit;
  assign sns_wr     = wr & (ofs[1:0] == PINSNS_OFS);
  assign flg_wr     = wr & (ofs[1:0] == PINFLG_OFS);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pinmsk <= 8'h00;
      pinsns <= 8'h00;
      devmsk <= DEV_M;
    end else if (wr) begin
      if (ofs[1:0] == PINMSK_OFS) pinmsk <= data_i & PIN_M;
      if (ofs[1:0] == PINSNS_OFS) pinsns <= data_i & SNS_M;
      if (ofs[1:0] == DEVMSK_OFS) devmsk <= data_i & DEV_M;
    end
  assign data_o = !selected_o               ? 8'h00 :
                  ofs[1:0] == PINMSK_OFS    ? pinmsk :
                  ofs[1:0] == PINSNS_OFS    ? pinsns :
                  ofs[1:0] == PINFLG_OFS    ? 8'(flg) : devmsk;
  for (genvar k = 0; k < N_PIN; k++) begin : g_pin
    irq_pin_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ena_i (ena_i),
      .pin_i (pin_irq_i[k]),
      .sns   (pinsns[2*k +: 2]),
      .guard (sns_wr),
      .clr   (irq_ack_i[k] | (flg_wr & data_i[k])),
      .msk   (pinmsk[k]),
      .flag  (flg[k]),
      .irq   (pin_irq[k])
    );
  end
  assign ext_irq_o = {dev_irq_i & devmsk[N_DEV-1:0], pin_irq};
endmodule

// File: tb/tb_irq_ctrl_n.sv
// tb_irq_ctrl_n: directed and randomised checks of irq_ctrl_n against a behavioural model
module tb_irq_ctrl_n;
  localparam int         N_PIN = 2;
  localparam int         N_DEV = 3;
  localparam int         SS    = 2;
  localparam logic [5:0] BASE  = 6'h38;
  localparam int         NI    = N_PIN + N_DEV;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             ena_i = 1'b1;
  logic [5:0]       adr_i = BASE;
  logic [7:0]       data_i = 8'h00;
  logic [7:0]       data_o;
  logic             re_i = 1'b0;
  logic             we_i = 1'b0;
  logic             selected_o;
  logic [N_PIN-1:0] pin_irq_i = '0;
  logic [N_DEV-1:0] dev_irq_i = '0;
  logic [N_PIN-1:0] irq_ack_i = '0;
  logic [NI-1:0]    ext_irq_o;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  irq_ctrl_n #(.N_PIN(N_PIN), .N_DEV(N_DEV), .BASE_ADR(BASE), .SYNC_STAGES(SS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .adr_i(adr_i), .data_i(data_i),
    .data_o(data_o), .re_i(re_i), .we_i(we_i), .selected_o(selected_o),
    .pin_irq_i(pin_irq_i), .dev_irq_i(dev_irq_i), .irq_ack_i(irq_ack_i),
    .ext_irq_o(ext_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: registers as plain values, pin history as a queue of past enabled samples
  bit [7:0]       m_msk, m_sns, m_dev;
  bit [N_PIN-1:0] m_flg;
  bit [N_PIN-1:0] smp[$];

  task automatic m_reset;
    m_msk = 8'h00;
    m_sns = 8'h00;
    m_dev = 8'((1 << N_DEV) - 1);
    m_flg = '0;
    smp.delete();
    repeat (SS + 1) smp.push_front('0);
  endtask

  function automatic int offs();
    return int'(adr_i) - int'(BASE);
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) m_reset();
    else if (ena_i) begin
      int o;
      bit w, ev;
      bit [N_PIN-1:0] ps, pq;
      bit [1:0] md;
      o  = offs();
      w  = we_i && o >= 0 && o < 4;
      ps = smp[SS-1];
      pq = smp[SS];
      for (int k = 0; k < N_PIN; k++) begin
        md = m_sns[2*k +: 2];
        ev = md == 2'b01 ? ps[k] != pq[k] : md == 2'b10 ? (pq[k] && !ps[k]) :
             md == 2'b11 ? (!pq[k] && ps[k]) : 1'b0;
        if (w && o == 1) ev = 0;
        if (md == 2'b00) m_flg[k] = 0;
        else if (ev) m_flg[k] = 1;
        else if (irq_ack_i[k] || (w && o == 2 && data_i[k])) m_flg[k] = 0;
      end
      if (w && o == 0) m_msk = data_i & 8'((1 << N_PIN) - 1);
      if (w && o == 1) m_sns = data_i & 8'((1 << (2 * N_PIN)) - 1);
      if (w && o == 3) m_dev = data_i & 8'((1 << N_DEV) - 1);
      smp.push_front(pin_irq_i);
      void'(smp.pop_back());
    end
  end

  always @(negedge clk_i) if (chk_on) begin
    int o;
    bit sel;
    bit [7:0] ed;
    bit [NI-1:0] ee;
    bit [N_PIN-1:0] ps;
    o   = offs();
    sel = (re_i || we_i) && o >= 0 && o < 4;
    ed  = !sel ? 8'h00 : o == 0 ? m_msk : o == 1 ? m_sns : o == 2 ? 8'(m_flg) : m_dev;
    ps  = smp[SS-1];
    for (int k = 0; k < N_PIN; k++)
      ee[k] = m_msk[k] && (m_sns[2*k +: 2] == 2'b00 ? !ps[k] : m_flg[k]);
    for (int j = 0; j < N_DEV; j++) ee[N_PIN+j] = dev_irq_i[j] && m_dev[j];
    cmp("model_sel", 32'(selected_o), 32'(sel));
    cmp("model_data", 32'(data_o), 32'(ed));
    cmp("model_ext", 32'(ext_irq_o), 32'(ee));
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic io_wr(input int o, input logic [7:0] d);
    adr_i  = 6'(int'(BASE) + o);
    data_i = d;
    we_i   = 1'b1;
    tick();
    we_i   = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int o, input logic [7:0] exp);
    adr_i = 6'(int'(BASE) + o);
    re_i  = 1'b1;
    #1;
    cmp(nm, 32'(data_o), 32'(exp));
    re_i  = 1'b0;
  endtask

  initial begin
    dev_irq_i = 3'b101;
    tick();
    chk_on = 1;
    tick();
    cmp("rst_ext", 32'(ext_irq_o), 32'(5'b10100));
    rd_chk("rst_pinmsk", 0, 8'h00);
    rd_chk("rst_pinsns", 1, 8'h00);
    rd_chk("rst_pinflg", 2, 8'h00);
    rd_chk("rst_devmsk", 3, 8'h07);
    rst_i = 1'b0;
    tick();
    // rising edge latency and acknowledge
    io_wr(1, 8'h03);
    io_wr(0, 8'h01);
    pin_irq_i[0] = 1'b1;
    tick();
    tick();
    cmp("rise_early", 32'(ext_irq_o[0]), 0);
    tick();
    cmp("rise_lat3", 32'(ext_irq_o[0]), 1);
    rd_chk("rise_flg", 2, 8'h01);
    irq_ack_i = 2'b01;
    tick();
    irq_ack_i = 2'b00;
    cmp("rise_ack", 32'(ext_irq_o[0]), 0);
    // masked falling capture and software clear
    io_wr(0, 8'h00);
    io_wr(1, 8'h08);
    pin_irq_i[1] = 1'b1;
    repeat (4) tick();
    pin_irq_i[1] = 1'b0;
    repeat (4) tick();
    rd_chk("fall_flg", 2, 8'h02);
    cmp("fall_masked", 32'(ext_irq_o[1]), 0);
    io_wr(2, 8'h02);
    rd_chk("fall_clr", 2, 8'h00);
    // set wins over a simultaneous ack
    io_wr(1, 8'h0C);
    pin_irq_i[1] = 1'b1;
    tick();
    tick();
    irq_ack_i = 2'b10;
    tick();
    irq_ack_i = 2'b00;
    rd_chk("set_wins", 2, 8'h02);
    irq_ack_i = 2'b10;
    tick();
    irq_ack_i = 2'b00;
    rd_chk("ack_clr", 2, 8'h00);
    // level mode ignores acks
    io_wr(1, 8'h00);
    io_wr(0, 8'h01);
    pin_irq_i[0] = 1'b0;
    repeat (4) tick();
    cmp("lvl_on", 32'(ext_irq_o[0]), 1);
    repeat (3) begin
      irq_ack_i = 2'b01;
      tick();
      irq_ack_i = 2'b00;
      cmp("lvl_ack", 32'(ext_irq_o[0]), 1);
    end
    // ena gating across an edge
    io_wr(1, 8'h03);
    ena_i = 1'b0;
    pin_irq_i[0] = 1'b1;
    repeat (10) tick();
    rd_chk("ena_hold_flg", 2, 8'h00);
    cmp("ena_hold_ext", 32'(ext_irq_o[0]), 0);
    ena_i = 1'b1;
    tick();
    tick();
    cmp("ena_early", 32'(ext_irq_o[0]), 0);
    tick();
    cmp("ena_resume", 32'(ext_irq_o[0]), 1);
    // device mask
    io_wr(3, 8'h02);
    dev_irq_i = 3'b111;
    #1;
    cmp("dev_msk_on", 32'(ext_irq_o[4:2]), 32'(3'b010));
    dev_irq_i = 3'b101;
    #1;
    cmp("dev_msk_off", 32'(ext_irq_o[4:2]), 0);
    // sense guard: stable rewrite, then a rewrite landing on an in-flight edge
    io_wr(1, 8'h0C);
    io_wr(2, 8'h03);
    repeat (4) tick();
    io_wr(1, 8'h08);
    repeat (4) tick();
    rd_chk("guard_stable", 2, 8'h00);
    pin_irq_i[1] = 1'b0;
    tick();
    tick();
    io_wr(1, 8'h08);
    repeat (4) tick();
    rd_chk("guard_inflight", 2, 8'h00);
    // randomised traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst_i = $urandom_range(0, 299) == 0;
      ena_i = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) pin_irq_i = pin_irq_i ^ N_PIN'($urandom);
      dev_irq_i = N_DEV'($urandom);
      irq_ack_i = $urandom_range(0, 7) == 0 ? N_PIN'($urandom) : '0;
      we_i   = $urandom_range(0, 5) == 0;
      re_i   = 1'($urandom);
      adr_i  = 6'(int'(BASE) - 1 + int'($urandom_range(0, 5)));
      data_i = 8'($urandom);
      tick();
    end
    we_i = 1'b0;
    re_i = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
